// File: rtl/mmio_pkg.sv
// Shared helpers for the memory-mapped register bank: map offsets, index width
// and the byte-strobe merge used by every writable word.
package mmio_pkg;

  localparam int IDX_W = 5;

  function automatic logic [31:0] chg_ofs(input int n);
    return 32'(4 * n);
  endfunction

  function automatic logic [31:0] ien_ofs(input int n);
    return 32'(4 * (n + 1));
  endfunction

  // Replace only the strobed byte lanes, then clear bits at and above dw.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb,
                                             input int          dw);
    logic [31:0] res;
    logic [31:0] mask;
    res = old_v;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
      else         res[8*k +: 8] = old_v[8*k +: 8];
    end
    mask = (dw >= 32) ? 32'hFFFF_FFFF : ((32'h0000_0001 << dw) - 32'h0000_0001);
    return res & mask;
  endfunction

endpackage

// File: rtl/mmio_change_detect.sv
// Sticky change flag for one sampled register; a new change outranks a
// same-cycle clear.
module mmio_change_detect #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] shadow,
  input  logic [W-1:0] prev,
  input  logic         clear,
  output logic         flag
);

  logic flag_q, flag_d;

  // Next flag: set on change, else W1C clear, else hold.
  always_comb begin
    flag_d = flag_q;
    if (shadow != prev) flag_d = 1'b1;
    else if (clear)     flag_d = 1'b0;
    else                flag_d = flag_q;
  end

  // Flag storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flag_q <= 1'b0;
    else          flag_q <= flag_d;
  end

  assign flag = flag_q;

endmodule

// File: rtl/mmio_reg_bank.sv
// Parametrised MMIO register bank on the picorv32 native bus. Defining
// MMIO_CHG_IRQ_EN adds the CHG/IEN words, change detection and irq.
module mmio_reg_bank
  import mmio_pkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter int          DATA_W    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0020,
  parameter logic [31:0] RO_MASK   = 32'h0000_0000,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       mem_valid,
  input  logic [31:0]                mem_addr,
  input  logic [31:0]                mem_wdata,
  input  logic [3:0]                 mem_wstrb,
  output logic                       mem_ready,
  output logic [31:0]                mem_rdata,
  output logic                       hit,
  input  logic [NUM_REGS*DATA_W-1:0] hw_in,
  output logic [NUM_REGS*DATA_W-1:0] hw_out,
  output logic                       irq
);

`ifdef MMIO_CHG_IRQ_EN
  localparam logic [31:0] MAP_LIMIT = ien_ofs(NUM_REGS) + 32'd4;
`else
  localparam logic [31:0] MAP_LIMIT = chg_ofs(NUM_REGS);
`endif

  logic [31:0]                ofs_s;
  logic [IDX_W-1:0]           idx_s;
  logic                       fire_s;
  logic                       wr_s;
  logic [31:0]                rd_val_s;
  logic [NUM_REGS*DATA_W-1:0] regs_s;
  logic                       ready_q;
  logic [31:0]                rdata_q;

  // Unsigned wrap makes addresses below BASE_ADDR fall out of range too.
  assign ofs_s  = mem_addr - BASE_ADDR;
  assign idx_s  = ofs_s[IDX_W+1:2];
  assign hit    = mem_valid && (ofs_s < MAP_LIMIT) && (mem_addr[1:0] == 2'b00);
  assign fire_s = hit && !ready_q;
  assign wr_s   = fire_s && (mem_wstrb != 4'b0000);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_W-1:0] reg_q, reg_d;

    if (RO_MASK[i]) begin : g_ro
      assign reg_d = hw_in[i*DATA_W +: DATA_W];
    end else begin : g_rw
      // Strobe-merged bus write into this register.
      always_comb begin
        reg_d = reg_q;
        if (wr_s && (idx_s == IDX_W'(i)))
          reg_d = DATA_W'(strb_merge(32'(reg_q), mem_wdata, mem_wstrb, DATA_W));
        else
          reg_d = reg_q;
      end
    end

    // Register or shadow storage.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) reg_q <= RO_MASK[i] ? {DATA_W{1'b0}} : RESET_VAL[DATA_W-1:0];
      else          reg_q <= reg_d;
    end

    assign regs_s[i*DATA_W +: DATA_W] = reg_q;
  end

  assign hw_out = regs_s;

`ifdef MMIO_CHG_IRQ_EN
  logic [NUM_REGS-1:0] chg_s, clr_s, ien_q, ien_d;
  logic                irq_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_chg
    if (RO_MASK[i]) begin : g_det
      logic [DATA_W-1:0] prev_q;

      // Previous-cycle copy of the shadow.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_q <= {DATA_W{1'b0}};
        else          prev_q <= regs_s[i*DATA_W +: DATA_W];
      end

      mmio_change_detect #(.W(DATA_W)) u_det (
        .clk     (clk),
        .reset_n (reset_n),
        .shadow  (regs_s[i*DATA_W +: DATA_W]),
        .prev    (prev_q),
        .clear   (clr_s[i]),
        .flag    (chg_s[i])
      );
    end else begin : g_none
      assign chg_s[i] = 1'b0;
    end
  end

  // W1C decode honours byte strobes.
  always_comb begin
    clr_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      clr_s[i] = wr_s && (idx_s == IDX_W'(NUM_REGS)) && mem_wdata[i] && mem_wstrb[i/8];
    end
  end

  // IEN write.
  always_comb begin
    ien_d = ien_q;
    if (wr_s && (idx_s == IDX_W'(NUM_REGS + 1)))
      ien_d = NUM_REGS'(strb_merge(32'(ien_q), mem_wdata, mem_wstrb, NUM_REGS));
    else
      ien_d = ien_q;
  end

  // IEN storage and registered interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ien_q <= {NUM_REGS{1'b0}};
      irq_q <= 1'b0;
    end else begin
      ien_q <= ien_d;
      irq_q <= |(chg_s & ien_q);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux, zero-extended.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_s == IDX_W'(i)) rd_val_s = 32'(regs_s[i*DATA_W +: DATA_W]);
      else                    rd_val_s = rd_val_s;
    end
`ifdef MMIO_CHG_IRQ_EN
    if (idx_s == IDX_W'(NUM_REGS))          rd_val_s = 32'(chg_s);
    else if (idx_s == IDX_W'(NUM_REGS + 1)) rd_val_s = 32'(ien_q);
    else                                    rd_val_s = rd_val_s;
`endif
  end

  // One-cycle acknowledge; rdata is zero outside the ack cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      ready_q <= fire_s;
      rdata_q <= fire_s ? rd_val_s : 32'h0000_0000;
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;

endmodule
